// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures the decoded instruction and its operands
// for the EX stage. It forwards write-back data into the operands because the
// register file commits on the same edge. It also provides stall/flush control
// and saturating debug counters for stall and flush events.
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_wreg,
    input  logic [DATA_W-1:0] wb_wdata,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              r_valid;
    logic [DATA_W-1:0] r_pc4;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic [DATA_W-1:0] r_imm;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [REG_AW-1:0] r_rd;
    logic [CTRL_W-1:0] r_ctrl;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic              w_byp1;
    logic              w_byp2;
    logic [DATA_W-1:0] w_op1;
    logic [DATA_W-1:0] w_op2;

    // Forward the write-back value when it targets a live, non-zero source register
    always_comb begin
        w_byp1 = wb_regwrite && (wb_wreg == id_rs) && (id_rs != '0);
        w_byp2 = wb_regwrite && (wb_wreg == id_rt) && (id_rt != '0);
        w_op1  = w_byp1 ? wb_wdata : id_rdata1;
        w_op2  = w_byp2 ? wb_wdata : id_rdata2;
    end

    // Pipeline payload: flush clears to a bubble, stall holds, otherwise load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_pc4   <= '0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_imm   <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_rd    <= '0;
            r_ctrl  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_pc4   <= '0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_imm   <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_rd    <= '0;
            r_ctrl  <= '0;
        end else if (!stall) begin
            r_valid <= id_valid;
            r_pc4   <= id_pc4;
            r_op1   <= w_op1;
            r_op2   <= w_op2;
            r_imm   <= id_imm;
            r_rs    <= id_rs;
            r_rt    <= id_rt;
            r_rd    <= id_rd;
            r_ctrl  <= id_ctrl;
        end
    end

    // Saturating stall counter; a stall that coincides with a flush does not count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (stall && !flush && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    // Saturating flush counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush_cnt <= '0;
        end else if (flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign ex_valid  = r_valid;
    assign ex_pc4    = r_pc4;
    assign ex_op1    = r_op1;
    assign ex_op2    = r_op2;
    assign ex_imm    = r_imm;
    assign ex_rs     = r_rs;
    assign ex_rt     = r_rt;
    assign ex_rd     = r_rd;
    assign ex_ctrl   = r_ctrl;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register directly downstream of the register file.
- Captures both register read operands, register specifiers, sign-extended immediate, PC+4 and the decoded control bundle at each clock edge, and presents them to the EX stage.
- Provides a write-back bypass, because the register file commits on the same edge that ID/EX samples.
- Supports stall (hold), flush (bubble insertion) and saturating stall/flush event counters for debug.

Parameters:
- DATA_W, 32, width of data operands, immediate and PC.
- REG_AW, 5, register specifier width.
- CTRL_W, 9, control bundle width. Bit map: [8] RegWrite, [7] MemtoReg, [6] MemRead, [5] MemWrite, [4] Branch, [3] ALUSrc, [2] RegDst, [1:0] ALUOp.
- CNT_W, 16, width of the event counters.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- stall  input  1  hold all EX-side state this cycle.
- flush  input  1  insert a bubble this cycle.
- id_valid  input  1  ID stage holds a real instruction.
- id_pc4  input  DATA_W  PC+4 of the ID instruction.
- id_rdata1  input  DATA_W  register-file ReadData1.
- id_rdata2  input  DATA_W  register-file ReadData2.
- id_rs  input  REG_AW  rs field.
- id_rt  input  REG_AW  rt field.
- id_rd  input  REG_AW  rd field.
- id_imm  input  DATA_W  sign-extended immediate.
- id_ctrl  input  CTRL_W  decoded control bundle.
- wb_regwrite  input  1  WB stage writes the register file this cycle.
- wb_wreg  input  REG_AW  WB destination register.
- wb_wdata  input  DATA_W  WB write data.
- ex_valid  output  1  EX holds a real instruction.
- ex_pc4, ex_op1, ex_op2, ex_imm  output  DATA_W  registered fields.
- ex_rs, ex_rt, ex_rd  output  REG_AW  registered specifiers.
- ex_ctrl  output  CTRL_W  registered control.
- stall_cnt  output  CNT_W  count of cycles with stall=1 and flush=0.
- flush_cnt  output  CNT_W  count of cycles with flush=1.

Behaviour:
- Reset (rst=1, asynchronous): every output is 0 immediately and held at 0 while rst=1. First capture happens on the first posedge after rst deasserts.
- Priority per posedge: flush > stall > normal load.
- Normal load (flush=0, stall=0):
  - All ex_* fields take their id_* counterparts, with ex_valid=id_valid.
  - Latency: 1 cycle.
- Bypass applies on normal load only:
  - op1 = wb_wdata if wb_regwrite=1, wb_wreg==id_rs and id_rs!=0; otherwise id_rdata1.
  - op2 is selected the same way using id_rt.
  - Register 0 is never bypassed; a $zero source always yields id_rdataN.
  - If wb_regwrite=0, values pass through unchanged even when the specifiers match.
- Flush:
  - ex_valid=0 and ex_ctrl=0, so RegWrite, MemRead and MemWrite are all 0 (bubble).
  - All data and specifier fields are cleared to 0.
  - flush_cnt increments.
  - A simultaneous stall is ignored and stall_cnt is not incremented.
- Stall (flush=0): all ex_* outputs hold their previous values, with no bypass update; stall_cnt increments.
- Counters:
  - Saturate at all-ones and never wrap.
  - Cleared only by rst.
- Bubble semantics: id_valid=0 on a normal load still copies id_ctrl verbatim. The decoder guarantees ctrl=0 for invalid instructions; this block does not mask it.
- Reset mid-stall or mid-flush: the asynchronous clear wins instantly, and the counters clear too.
- No combinational path from any input to any output.

Test Plan:
- Reset: rst=1 with random inputs -> all outputs 0 without waiting for a clock edge. Release rst, apply id_rdata1=10, id_rdata2=20, id_ctrl=9'h105, id_valid=1 -> one edge later ex_op1=10, ex_op2=20, ex_ctrl=9'h105, ex_valid=1.
- Bypass: id_rs=8, id_rdata1=10, wb_regwrite=1, wb_wreg=8, wb_wdata=99 -> ex_op1=99. Same stimulus with id_rs=id_rt=0 and wb_wreg=0 -> ex_op1=ex_op2=id_rdata values. Same stimulus with wb_regwrite=0 -> ex_op1=10.
- Stall: load op1=22, then stall=1 for 3 cycles while inputs change -> ex_op1 stays 22 and stall_cnt=3. On the next normal edge ex_op1 takes the new input.
- Flush with stall: flush=1 and stall=1 on the same edge -> ex_valid=0, ex_ctrl=0, all data 0, flush_cnt=1, stall_cnt unchanged.
- Saturation: CNT_W forced to 2, hold stall=1 for 5 cycles -> stall_cnt reads 3 and stays 3.
- Async reset mid-operation: assert rst between edges while stalled with stall_cnt=5 -> all outputs and both counters are 0 before the next posedge.
